// File: rtl/sram_ctrl_param_pkg.sv
// ---------------------------------------------------------------------------
// sram_ctrl_pkg
// Shared types and elaboration helpers for the parametrised SRAM controller.
//   state_t  : controller FSM states (IDLE, ACCESS, DONE)
//   beats_f  : number of narrow SRAM beats that make up one pipeline word
//   cnt_w    : counter width able to hold 0..n-1 (never narrower than 1 bit)
// ---------------------------------------------------------------------------
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    function automatic int beats_f(input int data_w, input int sram_dw);
        return data_w / sram_dw;
    endfunction

    // A counter that only ever holds 0 still needs one physical bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sram_ctrl_param_if.sv
// ---------------------------------------------------------------------------
// sram_ctrl_param_if
// Pipeline-side load/store handshake of the MEM-stage SRAM controller.
//   mem_r_en   : load request, level, held while stalled
//   mem_w_en   : store request, level, wins over mem_r_en
//   address    : word address
//   write_data : store data
//   read_data  : assembled load data (held until the next load)
//   not_ready  : stall request back to the pipeline
// Modports: master = pipeline side, slave = controller side.
// ---------------------------------------------------------------------------
interface sram_ctrl_param_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
);
    logic              mem_r_en;
    logic              mem_w_en;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              not_ready;

    modport master (
        output mem_r_en, mem_w_en, address, write_data,
        input  read_data, not_ready
    );

    modport slave (
        input  mem_r_en, mem_w_en, address, write_data,
        output read_data, not_ready
    );
endinterface

// File: rtl/sram_ctrl_param_beat_timer.sv
// ---------------------------------------------------------------------------
// sram_beat_timer
// Wait-cycle / beat-index counter pair for one word transfer.
//   clk, rst           : clock, asynchronous active-high reset
//   clr_i              : hold both counters at zero (outside an access)
//   en_i               : advance while an access is in progress
//   w_o                : cycle within the current beat, 0..WAIT_CYC-1
//   b_o                : beat index, 0..BEATS-1
//   beat_last_cycle_o  : current cycle is the last one of the beat
//   word_last_beat_o   : current beat is the last one of the word
// ---------------------------------------------------------------------------
module sram_beat_timer
    import sram_ctrl_pkg::*;
#(
    parameter int BEATS    = 2,
    parameter int WAIT_CYC = 5,
    parameter int BW       = cnt_w(BEATS),
    parameter int WW       = cnt_w(WAIT_CYC)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [WW-1:0] w_o,
    output logic [BW-1:0] b_o,
    output logic          beat_last_cycle_o,
    output logic          word_last_beat_o
);

    logic [WW-1:0] w_q, w_d;
    logic [BW-1:0] b_q, b_d;

    assign beat_last_cycle_o = (w_q == WW'(WAIT_CYC - 1));
    assign word_last_beat_o  = (b_q == BW'(BEATS - 1));
    assign w_o               = w_q;
    assign b_o               = b_q;

    always_comb begin
        w_d = w_q;
        b_d = b_q;
        if (clr_i) begin
            w_d = '0;
            b_d = '0;
        end else if (en_i) begin
            if (beat_last_cycle_o) begin
                w_d = '0;
                // Wrap the beat index at the end of the word so a non
                // power-of-two BEATS never leaves b out of range.
                b_d = word_last_beat_o ? '0 : b_q + BW'(1);
            end else begin
                w_d = w_q + WW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_q <= '0;
            b_q <= '0;
        end else begin
            w_q <= w_d;
            b_q <= b_d;
        end
    end

endmodule

// File: rtl/sram_ctrl_param.sv
// ---------------------------------------------------------------------------
// sram_ctrl_param
// MEM-stage SRAM controller: splits one DATA_W-bit load/store into
// BEATS = DATA_W/SRAM_DW accesses of WAIT_CYC cycles each on a narrow
// asynchronous SRAM, stalling the pipeline until the word is complete.
//   clk, rst   : clock, asynchronous active-high reset
//   pipe       : pipeline handshake (sram_ctrl_param_if.slave)
//   sram_addr  : SRAM halfword address (address*BEATS + beat)
//   sram_dq    : bidirectional SRAM data bus
//   sram_we_n  : write enable, active low
//   sram_oe_n  : output enable, active low
// A store has priority when both requests are present. The SRAM-side
// outputs are decoded from flops only, so request-input glitches never
// reach the SRAM, and reset drops sram_we_n without waiting for a clock.
// ---------------------------------------------------------------------------
module sram_ctrl_param
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int SRAM_DW  = 16,
    parameter int ADDR_W   = 16,
    parameter int SRAM_AW  = 18,
    parameter int WAIT_CYC = 5
) (
    input  logic                clk,
    input  logic                rst,
    sram_ctrl_param_if.slave    pipe,
    output logic [SRAM_AW-1:0]  sram_addr,
    inout  wire  [SRAM_DW-1:0]  sram_dq,
    output logic                sram_we_n,
    output logic                sram_oe_n
);

    localparam int BEATS = beats_f(DATA_W, SRAM_DW);
    localparam int BW    = cnt_w(BEATS);
    localparam int WW    = cnt_w(WAIT_CYC);

    // Parameter sanity, caught at elaboration.
    if (DATA_W % SRAM_DW != 0) begin : g_chk_ratio
        $error("sram_ctrl_param: DATA_W must be a multiple of SRAM_DW");
    end
    if (WAIT_CYC < 2) begin : g_chk_wait
        $error("sram_ctrl_param: WAIT_CYC must be at least 2");
    end
    if (SRAM_AW < ADDR_W + $clog2(BEATS)) begin : g_chk_aw
        $error("sram_ctrl_param: SRAM_AW too narrow for ADDR_W and BEATS");
    end

    state_t            state_q;
    logic              op_wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    logic [WW-1:0]     w_cnt;
    logic [BW-1:0]     b_cnt;
    logic              beat_last;
    logic              word_last;

    logic              req;
    logic              in_access;
    logic              wr_beat;
    logic [SRAM_DW-1:0] dq_out;

    assign req       = pipe.mem_r_en | pipe.mem_w_en;
    assign in_access = (state_q == ACCESS);
    assign wr_beat   = in_access & op_wr_q;

    sram_beat_timer #(
        .BEATS    (BEATS),
        .WAIT_CYC (WAIT_CYC),
        .BW       (BW),
        .WW       (WW)
    ) u_timer (
        .clk               (clk),
        .rst               (rst),
        .clr_i             (~in_access),
        .en_i              (in_access),
        .w_o               (w_cnt),
        .b_o               (b_cnt),
        .beat_last_cycle_o (beat_last),
        .word_last_beat_o  (word_last)
    );

    // Controller FSM. DONE always returns to IDLE so the request that is
    // still visible while the pipeline unfreezes is not taken twice.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        addr_q  <= pipe.address;
                        wdata_q <= pipe.write_data;
                        op_wr_q <= pipe.mem_w_en;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (beat_last) begin
                        // Sample at the end of the beat, after the full
                        // access time; beat 0 lands in the low slice.
                        if (!op_wr_q) begin
                            rdata_q[b_cnt*SRAM_DW +: SRAM_DW] <= sram_dq;
                        end
                        if (word_last) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // The write pulse ends one cycle before the beat does, so address and
    // data stay valid past the rising edge of sram_we_n.
    assign sram_we_n = ~(wr_beat & ~beat_last);
    assign sram_oe_n = ~(in_access & ~op_wr_q);
    assign sram_addr = in_access
                     ? (SRAM_AW'(addr_q) * SRAM_AW'(BEATS)) + SRAM_AW'(b_cnt)
                     : '0;

    assign dq_out  = wdata_q[b_cnt*SRAM_DW +: SRAM_DW];
    assign sram_dq = wr_beat ? dq_out : {SRAM_DW{1'bz}};

    assign pipe.read_data = rdata_q;
    // Stall starts combinationally in the request cycle and lasts through
    // every ACCESS cycle; DONE releases the pipeline.
    assign pipe.not_ready = in_access | ((state_q == IDLE) & req);

endmodule
